// File: rtl/alu_nibble_sequencer.sv
// Sequences an 8-bit ADD/SUB/AND/OR/XOR through an external combinational 4-bit ALU slice,
// low nibble first, then high nibble, and holds the assembled result until the consumer takes it.
module alu_nibble_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic [3:0] opcode,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [3:0] alu_op,
  output logic       alu_cin,
  input  logic [3:0] alu_result,
  input  logic       alu_cout,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] result,
  output logic       carry_out,
  output logic       zero,
  output logic       err,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] a_q, b_q;
  logic [3:0] op_q;
  logic       carry_q;
  logic [7:0] result_q;
  logic       carry_out_q, zero_q, err_q;
  logic       accept, legal, is_arith;

  // Both handshakes: a transfer happens on a rising edge where valid && ready are both 1;
  // in_ready is high only in IDLE and out_valid only in DONE, so the two never overlap.
  assign accept   = in_valid && (state_q == S_IDLE);
  assign legal    = (opcode <= 4'd4);
  assign is_arith = (op_q == 4'd0) || (op_q == 4'd1);
  assign state    = state_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (in_valid) state_d = legal ? S_LOW : S_DONE;
      S_LOW:  state_d = S_HIGH;
      S_HIGH: state_d = S_DONE;
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      carry_q     <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      zero_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            a_q         <= A;
            b_q         <= B;
            op_q        <= opcode;
            carry_q     <= 1'b0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            // An illegal opcode skips the slice and reports straight away.
            zero_q      <= !legal;
            err_q       <= !legal;
          end
        end
        S_LOW: begin
          result_q[3:0] <= alu_result;
          carry_q       <= is_arith && alu_cout;
        end
        S_HIGH: begin
          result_q[7:4] <= alu_result;
          carry_out_q   <= is_arith && alu_cout;
          zero_q        <= ({alu_result, result_q[3:0]} == 8'h00);
          err_q         <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    alu_a     = '0;
    alu_b     = '0;
    alu_op    = '0;
    alu_cin   = 1'b0;
    case (state_q)
      S_LOW: begin
        alu_a  = a_q[3:0];
        alu_b  = b_q[3:0];
        alu_op = op_q;
      end
      S_HIGH: begin
        alu_a   = a_q[7:4];
        alu_b   = b_q[7:4];
        alu_op  = op_q;
        alu_cin = is_arith && carry_q;
      end
      default: ;
    endcase
  end

  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign zero      = zero_q;
  assign err       = err_q;

endmodule
